uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 34 +++
 rtl/sync_2ff.sv | 33 +++
 rtl/uart_rx.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receiver.
// The PARITY state and parity helper exist only when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned DEF_CLK_RATE  = 100000000;
    localparam int unsigned DEF_BAUD_RATE = 3000000;

    typedef logic [7:0] byte_t;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_e;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input byte_t b);
        return ^b;
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } rx_state_e;
`endif

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous bit.
// Latency: 2 cycles. Backpressure: none.
// Reset value: RST_VAL.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_d, meta_q;
    logic sync_d, sync_q;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver (8E1 with UART_RX_PARITY_EN defined) feeding a one-byte holding register.
// Latency: byte on DATA_O/VALID_O the cycle after the stop-bit sample, plus 2 cycles of input sync.
// Backpressure: none on the line; a byte completing while the held byte is unconsumed is dropped (OVERRUN_O).
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_RATE  = DEF_CLK_RATE,
    parameter int unsigned BAUD_RATE = DEF_BAUD_RATE
) (
    input  logic       CLK_I,
    input  logic       RST_I,
    input  logic       RX_I,
    output logic [7:0] DATA_O,
    output logic       VALID_O,
    input  logic       READY_I,
    output logic       FRAME_ERR_O,
`ifdef UART_RX_PARITY_EN
    output logic       PARITY_ERR_O,
`endif
    output logic       OVERRUN_O
);

    localparam int unsigned CLKS_PER_BIT = CLK_RATE / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int          CNT_W        = $clog2(CLKS_PER_BIT + 1);

    logic rx_s;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (
        .clk (CLK_I),
        .rst (RST_I),
        .d   (RX_I),
        .q   (rx_s)
    );

    rx_state_e  state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [2:0] bit_cnt_d, bit_cnt_q;
    byte_t      shift_d, shift_q;
    byte_t      data_d, data_q;
    logic       valid_d, valid_q;
    logic       frame_err_d, frame_err_q;
    logic       overrun_d, overrun_q;
`ifdef UART_RX_PARITY_EN
    logic       par_bad_d, par_bad_q;
    logic       par_err_d, par_err_q;
`endif

    logic bit_tick;
    logic half_tick;
    logic byte_done;

    assign bit_tick  = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign half_tick = (cnt_q == CNT_W'(HALF_BIT - 1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        byte_done   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d   = par_bad_q;
        par_err_d   = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                bit_cnt_d = 3'd0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // Mid-start-bit check rejects short low glitches.
                if (half_tick) begin
                    cnt_d   = '0;
                    state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_tick) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bit_tick) begin
                    cnt_d     = '0;
                    par_bad_d = (rx_s != even_parity(shift_q));
                    par_err_d = par_bad_d;
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_tick) begin
                    cnt_d = '0;
                    if (rx_s) begin
`ifdef UART_RX_PARITY_EN
                        byte_done = !par_bad_q;
`else
                        byte_done = 1'b1;
`endif
                        state_d   = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        // A consume in the same cycle frees the register for the new byte.
        if (byte_done) begin
            if (valid_q && !READY_I) begin
                overrun_d = 1'b1;
            end else begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end
        end else if (valid_q && READY_I) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= 1'b0;
            par_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_PARITY_EN
            par_bad_q   <= par_bad_d;
            par_err_q   <= par_err_d;
`endif
        end
    end

    assign DATA_O      = data_q;
    assign VALID_O     = valid_q;
    assign FRAME_ERR_O = frame_err_q;
    assign OVERRUN_O   = overrun_q;
`ifdef UART_RX_PARITY_EN
    assign PARITY_ERR_O = par_err_q;
`endif

endmodule
